pipelined_digit_adder: RTL and testbench

Parametrised, fully pipelined add/subtract unit processing DIGIT bits of the operands per pipeline stage with a ripple carry between stages. It accepts one operation per cycle through a valid/ready input handshake, delivers results through a valid/ready output handshake with full backpressure, and is the general-purpose replacement for fixed one-bit-per-stage adders in arithmetic datapaths.

---
 rtl/pipelined_digit_adder_pkg.sv | 19 +
 rtl/digit_adder_stage.sv | 88 ++++++++
 rtl/pipelined_digit_adder.sv | 70 +++++++
 tb/tb_pipelined_digit_adder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_digit_adder_pkg.sv
// Shared helpers for pipelined_digit_adder: stage count and per-stage digit bounds.
package pipelined_digit_adder_pkg;

    function automatic int num_stages(input int width, input int digit);
        return (width + digit - 1) / digit;
    endfunction

    function automatic int digit_lo(input int k, input int digit);
        return k * digit;
    endfunction

    // Last stage is truncated to the remaining bits of the word.
    function automatic int digit_hi(input int k, input int width, input int digit);
        int hi;
        hi = (k + 1) * digit - 1;
        return (hi > width - 1) ? width - 1 : hi;
    endfunction

endpackage

// File: rtl/digit_adder_stage.sv
// One pipeline stage: ripples bits [HI:LO] and registers the partial word, remaining b bits and carry.
// With PIPELINED_DIGIT_ADDER_OVF_EN defined, the stage owning the MSB also registers signed overflow.
module digit_adder_stage
    import pipelined_digit_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LO    = 0,
    parameter int HI    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_word,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_word,
    output logic [WIDTH-1:0] o_b,
    output logic             o_carry,
    output logic             o_ovf
);

    localparam bit IS_LAST = (HI == WIDTH - 1);

    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_cmsb;
    logic             w_c;

    logic [WIDTH-1:0] r_word;
    logic             r_carry;
    logic             r_valid;

    always_comb begin
        w_sum  = i_word;
        w_c    = i_carry;
        w_cmsb = 1'b0;
        for (int i = LO; i <= HI; i++) begin
            if (i == WIDTH - 1) w_cmsb = w_c;
            w_sum[i] = i_word[i] ^ i_b[i] ^ w_c;
            w_c      = (i_word[i] & i_b[i]) | (w_c & (i_word[i] ^ i_b[i]));
        end
        w_carry = w_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word  <= '0;
            r_carry <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= w_sum;
            r_carry <= w_carry;
            r_valid <= i_valid;
        end
    end

    // Only the b bits still to be consumed travel forward.
    generate
        if (HI < WIDTH - 1) begin : g_fwd_b
            logic [WIDTH-1:HI+1] r_b;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      r_b <= '0;
                else if (i_load) r_b <= i_b[WIDTH-1:HI+1];
            end
            assign o_b = {r_b, {(HI + 1){1'b0}}};
        end else begin : g_no_b
            assign o_b = '0;
        end
    endgenerate

`ifdef PIPELINED_DIGIT_ADDER_OVF_EN
    logic r_ovf;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_ovf <= 1'b0;
        else if (i_load) r_ovf <= IS_LAST ? (w_cmsb ^ w_carry) : 1'b0;
    end
    assign o_ovf = r_ovf;
`else
    assign o_ovf = 1'b0;
`endif

    assign o_word  = r_word;
    assign o_carry = r_carry;
    assign o_valid = r_valid;

endmodule

// File: rtl/pipelined_digit_adder.sv
// Digit-serial pipelined add/subtract, DIGIT bits per stage, lock-step advance with full backpressure.
// Optional signed overflow output enabled by PIPELINED_DIGIT_ADDER_OVF_EN (otherwise ovf is 0).
module pipelined_digit_adder
    import pipelined_digit_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = num_stages(WIDTH, DIGIT);

    logic             w_adv;
    logic [WIDTH-1:0] w_word  [0:STAGES];
    logic [WIDTH-1:0] w_b     [0:STAGES];
    logic             w_carry [0:STAGES];
    logic             w_valid [0:STAGES];
    logic             w_ovf   [0:STAGES-1];

    // Every stage register shares one enable, so bubbles stay in place.
    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

    assign w_word[0]  = a;
    assign w_b[0]     = op ? ~b : b;
    assign w_carry[0] = cin;
    assign w_valid[0] = in_valid;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            digit_adder_stage #(
                .WIDTH (WIDTH),
                .LO    (digit_lo(k, DIGIT)),
                .HI    (digit_hi(k, WIDTH, DIGIT))
            ) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_adv),
                .i_valid (w_valid[k]),
                .i_word  (w_word[k]),
                .i_b     (w_b[k]),
                .i_carry (w_carry[k]),
                .o_valid (w_valid[k+1]),
                .o_word  (w_word[k+1]),
                .o_b     (w_b[k+1]),
                .o_carry (w_carry[k+1]),
                .o_ovf   (w_ovf[k])
            );
        end
    endgenerate

    assign s         = w_word[STAGES];
    assign cout      = w_carry[STAGES];
    assign out_valid = w_valid[STAGES];
    assign ovf       = w_ovf[STAGES-1];

endmodule

// File: tb/tb_pipelined_digit_adder.sv
// Directed bench for pipelined_digit_adder: main 16/4 build plus 10/4, 16/1 and 16/16 corner builds.
module tb_pipelined_digit_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        op;
    logic [15:0] a, b;
    logic        cin;
    logic        out_ready;
    logic        aux_ready;

    logic        in_ready, out_valid, cout, ovf;
    logic [15:0] s;

    logic        w10_in_ready, w10_out_valid, w10_cout, w10_ovf;
    logic [9:0]  w10_s;
    logic        d1_in_ready, d1_out_valid, d1_cout, d1_ovf;
    logic [15:0] d1_s;
    logic        dw_in_ready, dw_out_valid, dw_cout, dw_ovf;
    logic [15:0] dw_s;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef PIPELINED_DIGIT_ADDER_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    pipelined_digit_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf));

    pipelined_digit_adder #(.WIDTH(10), .DIGIT(4)) dut_w10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w10_in_ready), .op(op),
        .a(a[9:0]), .b(b[9:0]), .cin(cin), .out_valid(w10_out_valid), .out_ready(aux_ready),
        .s(w10_s), .cout(w10_cout), .ovf(w10_ovf));

    pipelined_digit_adder #(.WIDTH(16), .DIGIT(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d1_in_ready), .op(op),
        .a(a), .b(b), .cin(cin), .out_valid(d1_out_valid), .out_ready(aux_ready),
        .s(d1_s), .cout(d1_cout), .ovf(d1_ovf));

    pipelined_digit_adder #(.WIDTH(16), .DIGIT(16)) dut_dw (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(dw_in_ready), .op(op),
        .a(a), .b(b), .cin(cin), .out_valid(dw_out_valid), .out_ready(aux_ready),
        .s(dw_s), .cout(dw_cout), .ovf(dw_ovf));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Results of the most recent single operation, per build (lat 0 = never seen).
    int          lat_m, lat_w, lat_1, lat_f;
    logic [15:0] s_m, s_1, s_f;
    logic [9:0]  s_w;
    logic        c_m, c_w, c_1, c_f, o_m;

    task automatic do_op(input logic iop, input logic [15:0] ia, input logic [15:0] ib, input logic icin);
        @(negedge clk);
        op = iop; a = ia; b = ib; cin = icin; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat_m = 0; lat_w = 0; lat_1 = 0; lat_f = 0;
        for (int n = 1; n <= 24; n++) begin
            if (n > 1) @(negedge clk);
            if (lat_m == 0 && out_valid)     begin lat_m = n; s_m = s;     c_m = cout; o_m = ovf; end
            if (lat_w == 0 && w10_out_valid) begin lat_w = n; s_w = w10_s; c_w = w10_cout; end
            if (lat_1 == 0 && d1_out_valid)  begin lat_1 = n; s_1 = d1_s;  c_1 = d1_cout; end
            if (lat_f == 0 && dw_out_valid)  begin lat_f = n; s_f = dw_s;  c_f = dw_cout; end
        end
    endtask

    // Stream vectors: op, a, b, cin, hand-computed s and cout.
    logic        v_op  [0:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] v_a   [0:7] = '{16'h0001, 16'hFFFF, 16'h1000, 16'hABCD, 16'h0000, 16'h8000, 16'h00F0, 16'h1234};
    logic [15:0] v_b   [0:7] = '{16'h0002, 16'h0001, 16'h0001, 16'h1111, 16'h0001, 16'h8000, 16'h000F, 16'h1234};
    logic        v_cin [0:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] v_s   [0:7] = '{16'h0003, 16'h0000, 16'h0FFF, 16'hBCDE, 16'hFFFF, 16'h0001, 16'h0100, 16'h0000};
    logic        v_c   [0:7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        logic [31:0] pat;
        int          sent, rcvd, lat;
        logic        prev_stall, prev_c, seen;
        logic [15:0] prev_s;

        rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; cin = 1'b0;
        out_ready = 1'b1; aux_ready = 1'b1;
        #12;
        chk("reset_s", s, 16'h0000);
        chk("reset_cout", cout, 1'b0);
        chk("reset_ovf", ovf, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(1'b0, 16'h1234, 16'h0FFF, 1'b0);
        chk("add_s", s_m, 16'h2233);
        chk("add_cout", c_m, 1'b0);
        chk("add_latency", lat_m, 4);
        chk("d1_add_s", s_1, 16'h2233);
        chk("d1_latency", lat_1, 16);
        chk("dw_add_s", s_f, 16'h2233);
        chk("dw_latency", lat_f, 1);

        do_op(1'b0, 16'hFFFF, 16'h0000, 1'b1);
        chk("carry_all_s", s_m, 16'h0000);
        chk("carry_all_cout", c_m, 1'b1);
        chk("carry_all_ovf", o_m, 1'b0);
        chk("d1_carry_all_cout", c_1, 1'b1);
        chk("dw_carry_all_cout", c_f, 1'b1);

        do_op(1'b1, 16'h0005, 16'h0007, 1'b1);
        chk("sub_s", s_m, 16'hFFFE);
        chk("sub_cout", c_m, 1'b0);
        chk("sub_ovf", o_m, 1'b0);

        do_op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
        chk("ovf_add_s", s_m, 16'h8000);
        chk("ovf_add_ovf", o_m, OVF_ON);

        do_op(1'b1, 16'h8000, 16'h0001, 1'b1);
        chk("ovf_sub_s", s_m, 16'h7FFF);
        chk("ovf_sub_cout", c_m, 1'b1);
        chk("ovf_sub_ovf", o_m, OVF_ON);

        do_op(1'b0, 16'h03FF, 16'h0001, 1'b0);
        chk("w10_s", s_w, 10'h000);
        chk("w10_cout", c_w, 1'b1);
        chk("w10_latency", lat_w, 3);
        chk("w16_same_op_s", s_m, 16'h0400);

        // Back-to-back stream under a fixed pseudo-random out_ready pattern.
        pat = 32'hB2E69C5B;
        sent = 0; rcvd = 0; prev_stall = 1'b0; prev_s = '0; prev_c = 1'b0;
        for (int cyc = 0; cyc < 80 && rcvd < 8; cyc++) begin
            @(negedge clk);
            out_ready = pat[cyc % 32];
            if (sent < 8) begin
                in_valid = 1'b1; op = v_op[sent]; a = v_a[sent]; b = v_b[sent]; cin = v_cin[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("stream_in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                chk("stall_s_stable", s, prev_s);
                chk("stall_cout_stable", cout, prev_c);
                chk("stall_valid_held", out_valid, 1'b1);
            end
            if (out_valid && out_ready) begin
                chk("stream_s", s, v_s[rcvd]);
                chk("stream_cout", cout, v_c[rcvd]);
                rcvd++;
            end
            prev_stall = out_valid && !out_ready;
            prev_s = s;
            prev_c = cout;
            if (in_valid && in_ready) sent++;
        end
        chk("stream_count", rcvd, 8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(negedge clk);

        // Fill the pipe under backpressure, then reset with operations in flight.
        out_ready = 1'b0; op = 1'b0; a = 16'h1234; b = 16'h0FFF; cin = 1'b0; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            if (out_valid) lat = n;
            else @(negedge clk);
        end
        chk("inflight_out_valid", out_valid, 1'b1);
        chk("inflight_stall_s", s, 16'h2233);
        chk("inflight_in_ready", in_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", out_valid, 1'b0);
        chk("async_reset_s", s, 16'h0000);
        chk("async_reset_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        chk("post_reset_in_ready", in_ready, 1'b1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("post_reset_no_output", seen, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

endmodule
